// File: rtl/alu_if.sv
// Execute-stage ALU bus: operand issue handshake plus registered result/flags.
interface alu_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flags_clr;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             busy;

    modport master (
        output in_valid, op, op_a, op_b, flags_clr,
        input  in_ready, out_valid, result, flags, busy
    );

    modport slave (
        input  in_valid, op, op_a, op_b, flags_clr,
        output in_ready, out_valid, result, flags, busy
    );
endinterface

// File: rtl/pipelined_alu_core.sv
// Registered execute-stage ALU with persistent {Z,N,C,V} flags and an
// iterative shift-add multiplier that stalls the issuing stage.
module pipelined_alu_core #(
    parameter int WIDTH = 8
) (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_ADC = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_SBC = 4'h3;
    localparam logic [3:0] OP_INC = 4'h4;
    localparam logic [3:0] OP_DEC = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_NOT = 4'h9;
    localparam logic [3:0] OP_SHL = 4'hA;
    localparam logic [3:0] OP_SHR = 4'hB;
    localparam logic [3:0] OP_MUL = 4'hC;

    typedef enum logic {
        IDLE,
        MUL_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   result_q;
    logic [3:0]         flags_q;
    logic               out_valid_q;

    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic               mul_ovf;
    logic [WIDTH-1:0]   add_y;
    logic               add_cin;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;

    assign accept    = bus.in_valid && (state_q == IDLE);
    assign mul_start = accept && (bus.op == OP_MUL);
    assign mul_done  = (state_q == MUL_RUN) && (cnt_q == CNT_W'(WIDTH - 1));
    assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_ovf   = |acc_next[2*WIDTH-1:WIDTH];

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q == MUL_RUN);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

    // State register for the multiply sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: enter MUL_RUN on a multiply accept, leave after the last iteration.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mul_start) state_d = MUL_RUN;
            MUL_RUN: if (mul_done)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Single-cycle datapath: one shared adder selects its second operand and carry-in per op.
    always_comb begin
        add_y   = '0;
        add_cin = 1'b0;
        alu_res = bus.op_a;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.op)
            OP_ADD: begin add_y = bus.op_b;  add_cin = 1'b0;       end
            OP_ADC: begin add_y = bus.op_b;  add_cin = flags_q[1]; end
            OP_SUB: begin add_y = ~bus.op_b; add_cin = 1'b1;       end
            OP_SBC: begin add_y = ~bus.op_b; add_cin = flags_q[1]; end
            OP_INC: begin add_y = '0;        add_cin = 1'b1;       end
            OP_DEC: begin add_y = '1;        add_cin = 1'b0;       end
            default: ;
        endcase
        sum = {1'b0, bus.op_a} + {1'b0, add_y} + (WIDTH + 1)'(add_cin);
        case (bus.op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_INC, OP_DEC: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (bus.op_a[WIDTH-1] == add_y[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.op_a[WIDTH-1]);
            end
            OP_AND: alu_res = bus.op_a & bus.op_b;
            OP_OR:  alu_res = bus.op_a | bus.op_b;
            OP_XOR: alu_res = bus.op_a ^ bus.op_b;
            OP_NOT: alu_res = ~bus.op_a;
            OP_SHL: begin
                alu_res = {bus.op_a[WIDTH-2:0], 1'b0};
                alu_c   = bus.op_a[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, bus.op_a[WIDTH-1:1]};
                alu_c   = bus.op_a[0];
            end
            default: alu_res = bus.op_a;
        endcase
    end

    // Multiply engine: latch operands on accept, then one shift-add step per clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (mul_start) begin
            cnt_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, bus.op_a};
            mplier_q <= bus.op_b;
            acc_q    <= '0;
        end else if (state_q == MUL_RUN) begin
            cnt_q    <= cnt_q + CNT_W'(1);
            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            acc_q    <= acc_next;
        end
    end

    // Output register: result write takes priority over a concurrent flags_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if (accept && (bus.op != OP_MUL)) begin
                out_valid_q <= 1'b1;
                result_q    <= alu_res;
                flags_q     <= {(alu_res == '0), alu_res[WIDTH-1], alu_c, alu_v};
            end else if (mul_done) begin
                out_valid_q <= 1'b1;
                result_q    <= acc_next[WIDTH-1:0];
                flags_q     <= {(acc_next[WIDTH-1:0] == '0), acc_next[WIDTH-1],
                                mul_ovf, mul_ovf};
            end else if (bus.flags_clr) begin
                flags_q     <= '0;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_alu_core.sv
// Directed-vector bench for pipelined_alu_core at WIDTH=8.
module tb_pipelined_alu_core;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   pulses;

    alu_if #(.WIDTH(8)) bus ();

    pipelined_alu_core #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one op for a single accept edge; returns #1 after that edge.
    task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.op_a     = a;
        bus.op_b     = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [7:0] res, input logic [3:0] flg);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".result"},    32'(bus.result),    32'(res));
        check({tag, ".flags"},     32'(bus.flags),     32'(flg));
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.op       = 4'h0;
        bus.op_a     = 8'h00;
        bus.op_b     = 8'h00;
        bus.flags_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready",  32'(bus.in_ready),  32'd1);
        check("rst.busy",      32'(bus.busy),      32'd0);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.result",    32'(bus.result),    32'd0);
        check("rst.flags",     32'(bus.flags),     32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ADD wraps with carry: FF+01 -> 00, Z C
        issue(4'h0, 8'hFF, 8'h01);
        check_out("add_ff_01", 8'h00, 4'b1010);
        check("add.one_pulse", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        check("idle.out_valid", 32'(bus.out_valid), 32'd0);
        check("idle.result_hold", 32'(bus.result), 32'd0);

        // SUB 80-01 -> 7F, signed overflow, no borrow
        issue(4'h2, 8'h80, 8'h01);
        check_out("sub_80_01", 8'h7F, 4'b0011);
        // SBC 00-00 with C=1 -> 00, Z C
        issue(4'h3, 8'h00, 8'h00);
        check_out("sbc_00_00", 8'h00, 4'b1010);

        // Back-to-back ADD then ADC: 16-bit add of 00FF+0001
        bus.in_valid = 1'b1;
        bus.op = 4'h0; bus.op_a = 8'hFF; bus.op_b = 8'h01;
        @(posedge clk);
        #1;
        check_out("b2b_add", 8'h00, 4'b1010);
        bus.op = 4'h1; bus.op_a = 8'h00; bus.op_b = 8'h00;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_out("b2b_adc", 8'h01, 4'b0000);
        @(posedge clk);
        #1;
        check("b2b.end_pulse", 32'(bus.out_valid), 32'd0);

        // Logic, shift and inc/dec ops
        issue(4'h8, 8'hA5, 8'h0F); check_out("xor", 8'hAA, 4'b0100);
        issue(4'h9, 8'hF0, 8'h00); check_out("not", 8'h0F, 4'b0000);
        issue(4'hA, 8'h81, 8'h00); check_out("shl", 8'h02, 4'b0010);
        issue(4'hB, 8'h01, 8'h00); check_out("shr", 8'h00, 4'b1010);
        issue(4'h4, 8'h7F, 8'h00); check_out("inc", 8'h80, 4'b0101);
        issue(4'h5, 8'h00, 8'h00); check_out("dec", 8'hFF, 4'b0100);
        issue(4'h6, 8'hF0, 8'h3C); check_out("and", 8'h30, 4'b0000);
        issue(4'h7, 8'h00, 8'h00); check_out("or",  8'h00, 4'b1000);
        issue(4'hE, 8'h5A, 8'h33); check_out("pass", 8'h5A, 4'b0000);

        // MUL 0F*11 = FF; junk on in_valid while busy must be ignored
        issue(4'hC, 8'h0F, 8'h11);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("mul.in_ready_c%0d", i), 32'(bus.in_ready), 32'd0);
            check($sformatf("mul.no_valid_c%0d", i), 32'(bus.out_valid), 32'd0);
            bus.in_valid = 1'b1;
            bus.op   = 4'h0;
            bus.op_a = 8'(i);
            bus.op_b = 8'h55;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check("mul.ready_back", 32'(bus.in_ready), 32'd1);
        check_out("mul_0f_11", 8'hFF, 4'b0100);
        @(posedge clk);
        #1;
        check("mul.single_pulse", 32'(bus.out_valid), 32'd0);

        // MUL 10*10 = 0100 -> low byte 00, overflow
        issue(4'hC, 8'h10, 8'h10);
        repeat (8) @(posedge clk);
        #1;
        check_out("mul_10_10", 8'h00, 4'b1011);

        // Reset in cycle t+4 of a multiply aborts it
        issue(4'hC, 8'h03, 8'h05);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort.in_ready", 32'(bus.in_ready), 32'd1);
        check("abort.busy",     32'(bus.busy),     32'd0);
        check("abort.flags",    32'(bus.flags),    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid) pulses++;
            @(posedge clk);
            #1;
        end
        check("abort.no_pulse", 32'(pulses), 32'd0);
        issue(4'h0, 8'h01, 8'h01);
        check_out("abort.add", 8'h02, 4'b0000);

        // flags_clr coinciding with a result write: the write wins
        bus.flags_clr = 1'b1;
        issue(4'h0, 8'hFF, 8'h01);
        check_out("clr_vs_write", 8'h00, 4'b1010);
        @(posedge clk);
        #1;
        bus.flags_clr = 1'b0;
        check("clr_alone.flags",  32'(bus.flags),  32'd0);
        check("clr_alone.result", 32'(bus.result), 32'd0);
        check("clr_alone.valid",  32'(bus.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
